data_sram_responder: RTL
========================

Name: data_sram_responder

Overview:
Responder end of the CPU data-memory interface: accepts load/store requests issued by the MEM stage (req/wr/size/addr/wstrb/wdata) and returns completion (data_ok, rdata, err) after a fixed latency. Word-organised behavioural data RAM with byte-lane writes, one outstanding request. Serves as the dram target for the 5-stage core in simulation and on FPGA.

Parameters:
AW, 12, word-address width; memory holds 2^AW 32-bit words; byte addresses use addr[AW+1:2].
LAT, 1, cycles from accept to data_ok; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  1  request valid from MEM stage
wr  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 half, 10 word; 11 illegal
addr  in  32  byte address
wstrb  in  4  byte-lane write enables, store only
wdata  in  32  store data, lane-aligned
addr_ok  out  1  request accepted this cycle when req && addr_ok
data_ok  out  1  one-cycle completion pulse
rdata  out  32  full read word, valid while data_ok && !wr_latched
err  out  1  completion is an error, valid with data_ok

Behaviour:
- Clock clk; reset rst is asynchronous and active-high. Asserting rst: state->IDLE, data_ok=0, err=0, rdata=0, cnt=0. addr_ok=0 while rst is high. RAM contents are not reset.
- States: IDLE, WAIT, RESP. addr_ok = (state==IDLE) && !rst. Combinational in state only, never in req.
- Accept at cycle T (IDLE, req=1): latch wr, size, addr, wstrb, wdata. If LAT==1, go to RESP. Else go to WAIT with cnt=LAT-1.
- WAIT: cnt decrements each cycle. At cnt==1, go to RESP. data_ok asserts at exactly cycle T+LAT.
- RESP: data_ok=1 for one cycle, then IDLE. addr_ok returns at T+LAT+1. Peak throughput is one request per LAT+1 cycles.
- Misalignment check on the latched request. Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size==11. A misaligned request completes normally with err=1, performs no write, and returns rdata=0.
- Load: rdata is registered on the edge entering RESP, from mem[addr[AW+1:2]]. It is the full 32-bit word; lane extraction and sign extension are done by the CPU. rdata holds its value outside data_ok.
- Store: on the edge ending the RESP cycle, each lane i with wstrb[i]=1 takes wdata[8i+7:8i]. wstrb=0000 completes with no change. On a store, rdata is unchanged and err=0 unless misaligned.
- Address bits above AW+1 are ignored; addresses wrap modulo 2^(AW+2) bytes.
- req while not IDLE is ignored; the requester holds it until addr_ok.
- A load issued after a completed store to the same word returns the new data.
- Reset in WAIT or RESP: the request is dropped, no data_ok is issued, and a pending store is not committed.
- LAT outside 1..15 is an elaboration error.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum {IDLE, WAIT, RESP}.
  - misalign function (size, addr[1:0]) -> bit. The CPU MEM stage reuses it for its exception check.
- One sub-module, dsram_core: synchronous 2^AW x 32 RAM with 4-bit byte write enable and a registered read port. The responder FSM, counter and latches live in the top.

Test Plan:
1. After reset, LAT=1: store word addr=0x10, wdata=0xDEADBEEF, wstrb=1111 at T -> data_ok=1, err=0 at T+1. A load of 0x10 accepted at T+2 -> data_ok at T+3 with rdata=0xDEADBEEF.
2. Byte lanes: after case 1, store wstrb=0100, wdata=0x00AA0000 to 0x10 -> a subsequent load returns 0xDEAABEEF. A store with wstrb=0000 leaves the word unchanged.
3. LAT=4: req held high from cycle 0 -> addr_ok=1 only at cycles 0, 5, 10, with data_ok pulses at cycles 4, 9, 14. Exactly one pulse per request.
4. Misalignment: word load at 0x13 -> data_ok with err=1 and rdata=0. A half store at 0x21 -> err=1, and a following word load of 0x20 returns the prior contents.
5. Reset mid-operation, LAT=4: accept a store to 0x40 at T, assert rst asynchronously at T+2 -> data_ok never pulses, addr_ok=0 during reset and 1 after release. A load of 0x40 returns the pre-store value.
6. Wrap, AW=12: store 0x12345678 to 0x4008 -> a load of 0x0008 returns 0x12345678.

Source files
------------

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the CPU data-memory interface: access size
// encodings, the responder state type, and the misalignment rule. The MEM
// stage of the core imports the same misalign() so that its exception check
// and the responder's err flag can never disagree.
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A half must sit on an even byte and a word on a 4-byte boundary.
    // The unused size code 2'b11 is treated as misaligned so it can never
    // write memory.
    function automatic logic misalign(input logic [1:0] size, input logic [1:0] lsb);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lsb[0];
            SZ_WORD: bad = (lsb != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dsram_core.sv
// ---------------------------------------------------------------------------
// dsram_core
// Behavioural 2^AW x 32 synchronous RAM with per-byte write enables and a
// registered read port.
// Ports:
//   clk    : rising-edge clock
//   rst    : async active-high reset, clears only the read register
//   we     : byte-lane write enables (lane i = bits 8i+7:8i)
//   waddr  : word write address
//   wdata  : lane-aligned write data
//   rd_en  : capture mem[raddr] into rdata on this edge
//   rd_clr : force rdata to zero on this edge (takes priority over rd_en)
//   raddr  : word read address
//   rdata  : registered read data, held between reads
// ---------------------------------------------------------------------------
module dsram_core #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          rd_en,
    input  logic          rd_clr,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    // Array contents are deliberately not reset so it maps onto block RAM.
    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read register; clearing it is how an errored load returns zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_clr) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
// Responder end of the CPU data-memory interface. Accepts one load/store at a
// time from the MEM stage and completes it exactly LAT cycles after accept
// with a single-cycle data_ok pulse.
// Ports:
//   clk, rst : rising-edge clock, async active-high reset
//   req      : request valid (held by the requester until addr_ok)
//   wr       : 1 = store, 0 = load
//   size     : 00 byte, 01 half, 10 word, 11 illegal
//   addr     : byte address (bits above AW+1 ignored, i.e. wraps)
//   wstrb    : store byte-lane enables
//   wdata    : store data, lane-aligned
//   addr_ok  : responder is idle and will accept req this cycle
//   data_ok  : completion pulse
//   rdata    : full 32-bit read word for loads, zero on an errored request
//   err      : completion is a misalignment error
// ---------------------------------------------------------------------------
module data_sram_responder
    import dmem_pkg::*;
#(
    parameter int AW  = 12,
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    generate
        if (LAT < 1 || LAT > 15) begin : g_bad_lat
            $error("data_sram_responder: LAT must be in 1..15");
        end
    endgenerate

    state_t        state;
    state_t        state_next;
    logic [3:0]    cnt;
    logic          wr_q;
    logic [1:0]    size_q;
    logic [AW+1:0] addr_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   wdata_q;
    logic          err_q;

    logic          accept;
    logic          enter_resp;
    logic          cur_wr;
    logic [1:0]    cur_size;
    logic [AW+1:0] cur_addr;
    logic          cur_mis;
    logic          mis_q;
    logic [3:0]    we;
    logic          unused_addr_hi;

    // Only the word index and byte offset matter; the rest wrap away.
    assign unused_addr_hi = ^addr[31:AW+2];

    assign addr_ok = (state == IDLE) && !rst;
    assign data_ok = (state == RESP);
    assign err     = err_q;
    assign accept  = req && addr_ok;

    // With LAT==1 the accept edge is also the edge entering RESP, so the
    // read and error capture must look at the live inputs rather than the
    // latches, which only update on that same edge.
    assign cur_wr   = (state == IDLE) ? wr   : wr_q;
    assign cur_size = (state == IDLE) ? size : size_q;
    assign cur_addr = (state == IDLE) ? addr[AW+1:0] : addr_q;
    assign cur_mis  = misalign(cur_size, cur_addr[1:0]);
    assign mis_q    = misalign(size_q, addr_q[1:0]);

    assign enter_resp = (state == IDLE && accept && LAT == 1) ||
                        (state == WAIT && cnt == 4'd1);

    // Store commits on the edge that ends RESP; an async reset drops state
    // to IDLE first, so an interrupted store never reaches memory.
    assign we = (state == RESP && wr_q && !mis_q) ? wstrb_q : 4'b0000;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, count down the latency, pulse once.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (LAT == 1) ? RESP : WAIT;
            WAIT: if (cnt == 4'd1) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latency counter, loaded on accept so RESP lands exactly LAT cycles on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= 4'(LAT - 1);
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Request latches, captured once per accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            wr_q    <= wr;
            size_q  <= size;
            addr_q  <= addr[AW+1:0];
            wstrb_q <= wstrb;
            wdata_q <= wdata;
        end
    end

    // Error flag is set up alongside rdata so both are stable during RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (enter_resp) begin
            err_q <= cur_mis;
        end
    end

    dsram_core #(.AW(AW)) u_core (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (addr_q[AW+1:2]),
        .wdata  (wdata_q),
        .rd_en  (enter_resp && !cur_wr && !cur_mis),
        .rd_clr (enter_resp && cur_mis),
        .raddr  (cur_addr[AW+1:2]),
        .rdata  (rdata)
    );

endmodule
